// File: rtl/change_dispenser.sv
// change_dispenser: pays a requested amount (nickel units) as a serial stream of
// one-hot coin pulses, choosing coins greedily (quarter, dime, nickel).
// Build option CHANGE_DISPENSER_INV_EN: when defined, per-coin inventories are
// tracked, refilled and can run out (shortfall reported with done); when
// undefined, inventories are unlimited and read as the constant INV_INIT.
module change_dispenser #(
    parameter int AMT_W     = 5,
    parameter int INV_W     = 6,
    parameter int INV_INIT  = 8,
    parameter int PULSE_LEN = 2,
    parameter int GAP_LEN   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AMT_W-1:0] req_amt,
    input  logic             refill_n,
    input  logic             refill_d,
    input  logic             refill_q,
    output logic             nickle,
    output logic             dime,
    output logic             quarter,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] remaining,
    output logic [INV_W-1:0] inv_n,
    output logic [INV_W-1:0] inv_d,
    output logic [INV_W-1:0] inv_q
);

    localparam int CNT_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_LEN - 1);

    // Coin values in nickel units
    localparam logic [AMT_W-1:0] VAL_N = AMT_W'(1);
    localparam logic [AMT_W-1:0] VAL_D = AMT_W'(2);
    localparam logic [AMT_W-1:0] VAL_Q = AMT_W'(5);

    localparam logic [INV_W-1:0] INV_RST = INV_W'(INV_INIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_PULSE,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    // Chosen coin, one-hot: [0]=nickel, [1]=dime, [2]=quarter
    logic [2:0]       sel_q, sel_d;
    logic [2:0]       coins_q, coins_d;
    logic             done_q, done_d;
    logic             short_q, short_d;
    logic [AMT_W-1:0] remaining_q, remaining_d;
    logic             ready_q, ready_d;

    // Per-coin inventory non-empty flags and the decrement request from SELECT
    logic [2:0]       avail;
    logic [2:0]       dec;

    // Next-state and registered-output computation for the payout sequencer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        sel_d       = sel_q;
        dec         = '0;
        done_d      = 1'b0;
        short_d     = 1'b0;
        remaining_d = '0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    rem_d   = req_amt;
                    state_d = S_SELECT;
                end
            end

            S_SELECT: begin
                if ((rem_q >= VAL_Q) && avail[2]) begin
                    sel_d   = 3'b100;
                    dec     = 3'b100;
                    rem_d   = rem_q - VAL_Q;
                    cnt_d   = PULSE_LAST;
                    state_d = S_PULSE;
                end else if ((rem_q >= VAL_D) && avail[1]) begin
                    sel_d   = 3'b010;
                    dec     = 3'b010;
                    rem_d   = rem_q - VAL_D;
                    cnt_d   = PULSE_LAST;
                    state_d = S_PULSE;
                end else if ((rem_q >= VAL_N) && avail[0]) begin
                    sel_d   = 3'b001;
                    dec     = 3'b001;
                    rem_d   = rem_q - VAL_N;
                    cnt_d   = PULSE_LAST;
                    state_d = S_PULSE;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
`ifdef CHANGE_DISPENSER_INV_EN
                    short_d     = (rem_q != '0);
                    remaining_d = rem_q;
`endif
                end
            end

            S_PULSE: begin
                if (cnt_q == '0) begin
                    cnt_d   = GAP_LAST;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_SELECT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they can be registered
        coins_d = (state_d == S_PULSE) ? sel_d : '0;
        ready_d = (state_d == S_IDLE);
    end

    // Sequencer state and registered outputs; reset drops coin outputs at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            sel_q       <= '0;
            coins_q     <= '0;
            done_q      <= 1'b0;
            short_q     <= 1'b0;
            remaining_q <= '0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            sel_q       <= sel_d;
            coins_q     <= coins_d;
            done_q      <= done_d;
            short_q     <= short_d;
            remaining_q <= remaining_d;
            ready_q     <= ready_d;
        end
    end

    assign nickle    = coins_q[0];
    assign dime      = coins_q[1];
    assign quarter   = coins_q[2];
    assign done      = done_q;
    assign short     = short_q;
    assign remaining = remaining_q;
    assign req_ready = ready_q;

`ifdef CHANGE_DISPENSER_INV_EN
    logic [INV_W-1:0] inv_cnt_q [3];
    logic [INV_W-1:0] inv_cnt_d [3];
    logic [2:0]       refill;

    assign refill = {refill_q, refill_d, refill_n};

    // A coin type is selectable only while its inventory is non-empty
    always_comb begin
        avail = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            avail[i] = (inv_cnt_q[i] != '0);
        end
    end

    // Inventory update: saturating refill, decrement on payout, coincident pair cancels
    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            inv_cnt_d[i] = inv_cnt_q[i];
            if (refill[i] && !dec[i]) begin
                if (inv_cnt_q[i] != '1) begin
                    inv_cnt_d[i] = inv_cnt_q[i] + INV_W'(1);
                end
            end else if (!refill[i] && dec[i]) begin
                inv_cnt_d[i] = inv_cnt_q[i] - INV_W'(1);
            end
        end
    end

    // Inventory registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 3; i++) begin
                inv_cnt_q[i] <= INV_RST;
            end
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                inv_cnt_q[i] <= inv_cnt_d[i];
            end
        end
    end

    assign inv_n = inv_cnt_q[0];
    assign inv_d = inv_cnt_q[1];
    assign inv_q = inv_cnt_q[2];
`else
    logic unused_inv;

    // Unlimited inventory: every coin is always selectable
    assign avail      = '1;
    assign inv_n      = INV_RST;
    assign inv_d      = INV_RST;
    assign inv_q      = INV_RST;
    assign unused_inv = ^{refill_n, refill_d, refill_q, dec};
`endif

    // At most one coin output may be high in any cycle
    a_coin_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0({quarter, dime, nickle}));

    // The completion strobe never overlaps a coin pulse
    a_done_quiet: assert property (@(posedge clk) disable iff (rst)
        done |-> ({quarter, dime, nickle} == 3'b000));

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed scenarios plus randomized payouts/refills,
// checked every cycle against a schedule-based reference model.
`timescale 1ns/1ps
module tb_change_dispenser;

    localparam int AMT_W     = 5;
    localparam int INV_W     = 6;
    localparam int INV_INIT  = 8;
    localparam int PULSE_LEN = 2;
    localparam int GAP_LEN   = 1;
    localparam int INV_MAX   = (1 << INV_W) - 1;

`ifdef CHANGE_DISPENSER_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [AMT_W-1:0] req_amt;
    logic             refill_n;
    logic             refill_d;
    logic             refill_q;
    logic             nickle;
    logic             dime;
    logic             quarter;
    logic             done;
    logic             short;
    logic [AMT_W-1:0] remaining;
    logic [INV_W-1:0] inv_n;
    logic [INV_W-1:0] inv_d;
    logic [INV_W-1:0] inv_q;

    change_dispenser #(
        .AMT_W     (AMT_W),
        .INV_W     (INV_W),
        .INV_INIT  (INV_INIT),
        .PULSE_LEN (PULSE_LEN),
        .GAP_LEN   (GAP_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_amt   (req_amt),
        .refill_n  (refill_n),
        .refill_d  (refill_d),
        .refill_q  (refill_q),
        .nickle    (nickle),
        .dime      (dime),
        .quarter   (quarter),
        .done      (done),
        .short     (short),
        .remaining (remaining),
        .inv_n     (inv_n),
        .inv_d     (inv_d),
        .inv_q     (inv_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: the payout is a schedule of per-cycle coin slots.
    // Phase says what the current cycle is; slots hold upcoming coin indices (-1 = gap).
    typedef enum {PH_IDLE, PH_DECIDE, PH_SLOTS, PH_FINISH} phase_t;

    phase_t     phase;
    int         m_rem;
    int         m_inv [3];
    int         slots [$];
    int         coin_val [3] = '{1, 2, 5};
    logic [2:0] e_coin;
    bit         e_done;
    bit         e_ready;
    bit         e_short;
    int         e_remv;
    int         cyc;
    int         done_at;

    function automatic bit has_coin(input int idx);
        return !INV_EN || (m_inv[idx] > 0);
    endfunction

    task automatic model_idle();
        phase = PH_IDLE;
        slots.delete();
        m_rem = 0;
        for (int i = 0; i < 3; i++) m_inv[i] = INV_INIT;
        e_coin  = '0;
        e_done  = 1'b0;
        e_ready = 1'b1;
        e_short = 1'b0;
        e_remv  = 0;
        cyc     = 0;
    endtask

    // One clock cycle: check this cycle's outputs, drive inputs, predict the next cycle
    task automatic step(input bit v, input int amt, input bit rn, input bit rd, input bit rq);
        int ch;
        int s;
        bit [2:0] dec;
        bit [2:0] rf;
        @(negedge clk);
        check("ready", 32'(req_ready), 32'(e_ready));
        check("coins", 32'({quarter, dime, nickle}), 32'(e_coin));
        check("done", 32'(done), 32'(e_done));
        if (e_done) begin
            check("short", 32'(short), 32'(e_short));
            check("remaining", 32'(remaining), 32'(e_remv));
        end
        check("inv_n", 32'(inv_n), 32'(m_inv[0]));
        check("inv_d", 32'(inv_d), 32'(m_inv[1]));
        check("inv_q", 32'(inv_q), 32'(m_inv[2]));
        if (done === 1'b1) done_at = cyc;

        req_valid = v;
        req_amt   = AMT_W'(amt);
        refill_n  = rn;
        refill_d  = rd;
        refill_q  = rq;

        if (phase == PH_IDLE && v) cyc = 1;
        else cyc++;

        dec     = '0;
        rf      = {rq, rd, rn};
        e_coin  = '0;
        e_done  = 1'b0;
        e_short = 1'b0;
        e_remv  = 0;
        case (phase)
            PH_IDLE: begin
                if (v) begin
                    m_rem = amt;
                    phase = PH_DECIDE;
                end
            end
            PH_DECIDE: begin
                ch = -1;
                if (m_rem >= 5 && has_coin(2)) ch = 2;
                else if (m_rem >= 2 && has_coin(1)) ch = 1;
                else if (m_rem >= 1 && has_coin(0)) ch = 0;
                if (ch >= 0) begin
                    m_rem -= coin_val[ch];
                    dec[ch] = 1'b1;
                    repeat (PULSE_LEN) slots.push_back(ch);
                    repeat (GAP_LEN) slots.push_back(-1);
                    phase = PH_SLOTS;
                end else begin
                    e_done  = 1'b1;
                    e_short = INV_EN && (m_rem != 0);
                    e_remv  = INV_EN ? m_rem : 0;
                    phase   = PH_FINISH;
                end
            end
            PH_SLOTS: begin
                if (slots.size() == 0) phase = PH_DECIDE;
            end
            PH_FINISH: phase = PH_IDLE;
            default:   phase = PH_IDLE;
        endcase
        if (phase == PH_SLOTS) begin
            s = slots.pop_front();
            if (s >= 0) e_coin[s] = 1'b1;
        end
        e_ready = (phase == PH_IDLE);

        if (INV_EN) begin
            for (int i = 0; i < 3; i++) begin
                if (rf[i] && dec[i]) m_inv[i] = m_inv[i];
                else if (rf[i]) m_inv[i] = (m_inv[i] < INV_MAX) ? m_inv[i] + 1 : INV_MAX;
                else if (dec[i]) m_inv[i] = m_inv[i] - 1;
            end
        end
    endtask

    task automatic finish_payout();
        for (int i = 0; i < 400 && phase != PH_IDLE; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
    endtask

    task automatic payout(input int amt);
        done_at = -1;
        step(1, amt, 0, 0, 0);
        finish_payout();
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        req_amt   = '0;
        refill_n  = 1'b0;
        refill_d  = 1'b0;
        refill_q  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_coins", 32'({quarter, dime, nickle}), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_short", 32'(short), 32'd0);
        check("rst_remaining", 32'(remaining), 32'd0);
        check("rst_inv_n", 32'(inv_n), INV_INIT);
        check("rst_inv_d", 32'(inv_d), INV_INIT);
        check("rst_inv_q", 32'(inv_q), INV_INIT);
        rst = 1'b0;
        model_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_idle();
        done_at = -1;
        apply_reset();

        // 40 cents: quarter, dime, nickel; done in cycle 14
        payout(8);
        check("amt8_done_cycle", done_at, 14);
        check("amt8_inv_q", 32'(inv_q), INV_EN ? 7 : 8);
        check("amt8_inv_d", 32'(inv_d), INV_EN ? 7 : 8);
        check("amt8_inv_n", 32'(inv_n), INV_EN ? 7 : 8);

        // Zero amount: no coins, done in cycle 2
        payout(0);
        check("amt0_done_cycle", done_at, 2);

        // Refill coinciding with the quarter decrement, then saturation
        apply_reset();
        step(1, 5, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        finish_payout();
        check("refill_same_cycle_inv_q", 32'(inv_q), 8);
        repeat (63) step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        check("refill_saturate_inv_q", 32'(inv_q), INV_EN ? 63 : 8);

        // Reset during the second cycle of a dime pulse
        apply_reset();
        step(1, 2, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("pre_rst_dime", 32'(dime), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_coins", 32'({quarter, dime, nickle}), 32'd0);
        check("async_rst_ready", 32'(req_ready), 32'd1);
        check("async_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_idle();
        step(0, 0, 0, 0, 0);
        check("post_rst_inv_d", 32'(inv_d), INV_INIT);

        // req_valid held with a different amount during a payout
        done_at = -1;
        step(1, 4, 0, 0, 0);
        for (int i = 0; i < 100 && phase != PH_IDLE; i++) step(1, 9, 0, 0, 0);
        check("held_first_done_cycle", done_at, 10);
        done_at = -1;
        step(1, 9, 0, 0, 0);
        finish_payout();
        check("held_second_done_cycle", done_at, 14);

        // Drain to inv_q=0, inv_n=0, inv_d=1, then pay 3 units
        apply_reset();
        repeat (8) payout(1);
        repeat (8) payout(5);
        repeat (7) payout(2);
        payout(3);
        check("short_done_cycle", done_at, INV_EN ? 6 : 10);
        check("short_inv_d", 32'(inv_d), INV_EN ? 0 : 8);

        // Randomized requests and refills
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 31),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0);
        end
        finish_payout();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
